pwm_duty_decoder: RTL

Receive-side companion to the motor PWM generator. Samples a PWM line plus the H-bridge direction pair (in1/in2) and recovers the commanded duty cycle as an integer percent 0..100, the raw period and high time, and the rotation direction. Used for loopback self-test of the motor module and for measuring an externally supplied PWM command.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_div_seq.sv | 68 ++++++
 rtl/pwm_duty_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and direction decode for the PWM duty decoder.
// Pure declarations: no latency, no flow control.
package pwm_pkg;

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;

    localparam int PCT_W      = 7;
    localparam int DEF_PERIOD = 10001;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_MEASURE,
        ST_DIVIDE
    } state_t;

    // Both-high is treated like both-low: the bridge is braking, not driving.
    function automatic logic [1:0] dir_decode(input logic a, input logic b);
        case ({a, b})
            2'b10:   return DIR_FWD;
            2'b01:   return DIR_REV;
            default: return DIR_OFF;
        endcase
    endfunction

endpackage

// File: rtl/pwm_div_seq.sv
// Restoring divider producing a fixed 7-bit quotient; first step runs in the start cycle.
// Latency: done pulses 7 cycles after start; abort drops the division silently, no backpressure.
module pwm_div_seq
    import pwm_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W+PCT_W-1:0]   dividend,
    input  logic [CNT_W-1:0]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic [PCT_W-1:0]         quotient
);

    localparam int DW = CNT_W + PCT_W;

    logic [DW-1:0] rem;
    logic [DW-1:0] dsh;
    logic [2:0]    steps;
    logic [DW-1:0] rem_in;
    logic [DW-1:0] dsh_in;
    logic [DW-1:0] rem_nxt;
    logic          ge;

    // Caller guarantees dividend < divisor * 2^PCT_W, so starting at divisor << 6 loses nothing.
    always_comb begin
        rem_in  = start ? dividend : rem;
        dsh_in  = start ? (DW'(divisor) << (PCT_W - 1)) : dsh;
        ge      = (rem_in >= dsh_in);
        rem_nxt = ge ? (rem_in - dsh_in) : rem_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsh      <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                rem      <= rem_nxt;
                dsh      <= dsh_in >> 1;
                quotient <= {{(PCT_W-1){1'b0}}, ge};
                steps    <= 3'(PCT_W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= rem_nxt;
                dsh      <= dsh_in >> 1;
                quotient <= {quotient[PCT_W-2:0], ge};
                steps    <= steps - 3'd1;
                if (steps == 3'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers duty percent, period, high time and H-bridge direction from asynchronous inputs.
// Latency: valid 8 cycles after the internal rise closing a period (+2 sync); outputs are pulses, no backpressure.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int TIMEOUT    = 20000,
    parameter int MIN_PERIOD = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    input  logic               in1,
    input  logic               in2,
    output logic [PCT_W-1:0]   duty_pct,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   high_time,
    output logic               valid,
    output logic               stalled,
    output logic [1:0]         dir,
    output logic               dir_change
);

    localparam int DW   = CNT_W + PCT_W;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic pwm_s1, pwm_s2, pwm_d;
    logic in1_s1, in1_s2, in2_s1, in2_s2;
    logic rise, fall, fire, start;
    logic [CNT_W-1:0] per_cnt, hi_cnt, period_r, high_r;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       dir_nxt;
    logic [DW-1:0]    dividend;
    logic             div_busy, div_done;
    logic [PCT_W-1:0] div_q;
    state_t           state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {pwm_s1, pwm_s2, pwm_d}          <= '0;
            {in1_s1, in1_s2, in2_s1, in2_s2} <= '0;
        end else begin
            pwm_s1 <= pwm_in;
            pwm_s2 <= pwm_s1;
            pwm_d  <= pwm_s2;
            in1_s1 <= in1;
            in1_s2 <= in1_s1;
            in2_s1 <= in2;
            in2_s2 <= in2_s1;
        end
    end

    always_comb begin
        rise     = pwm_s2 & ~pwm_d;
        fall     = ~pwm_s2 & pwm_d;
        fire     = ~rise && (to_cnt == TO_W'(TIMEOUT - 1));
        start    = (state == ST_MEASURE) && rise && !div_busy
                   && (per_cnt >= CNT_W'(MIN_PERIOD));
        // Adding half the period before dividing rounds to nearest.
        dividend = DW'(hi_cnt) * DW'(100) + DW'(per_cnt >> 1);
        dir_nxt  = dir_decode(in1_s2, in2_s2);
    end

    // A falling edge on a stalled line rearms the timeout so the new level gets reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            to_cnt  <= '0;
        end else begin
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(pwm_s2);
            end else begin
                if (per_cnt != '1)
                    per_cnt <= per_cnt + 1'b1;
                if (pwm_s2 && hi_cnt != '1)
                    hi_cnt <= hi_cnt + 1'b1;
            end
            if (rise || (fall && stalled))
                to_cnt <= '0;
            else if (to_cnt != TO_W'(TIMEOUT))
                to_cnt <= to_cnt + 1'b1;
        end
    end

    pwm_div_seq #(.CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (fire),
        .dividend (dividend),
        .divisor  (per_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARM;
            period_r  <= '0;
            high_r    <= '0;
            duty_pct  <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rise)
                stalled <= 1'b0;
            if (fire) begin
                stalled   <= 1'b1;
                duty_pct  <= pwm_s2 ? PCT_W'(100) : '0;
                period    <= '0;
                high_time <= '0;
                valid     <= 1'b1;
                state     <= ST_ARM;
            end else begin
                case (state)
                    ST_ARM: begin
                        if (rise)
                            state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (start) begin
                            period_r <= per_cnt;
                            high_r   <= hi_cnt;
                            state    <= ST_DIVIDE;
                        end
                    end
                    ST_DIVIDE: begin
                        if (div_done) begin
                            duty_pct  <= div_q;
                            period    <= period_r;
                            high_time <= high_r;
                            valid     <= 1'b1;
                            state     <= ST_MEASURE;
                        end
                    end
                    default: state <= ST_ARM;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir        <= DIR_OFF;
            dir_change <= 1'b0;
        end else begin
            dir        <= dir_nxt;
            dir_change <= (dir_nxt != dir);
        end
    end

endmodule
